// File: rtl/multi_voice_synth.sv
// rtl/multi_voice_synth.sv - multi-voice square/noise synth with saturating mixer and PWM output
// Optional envelope FSM built only when SYNTH_ENV_EN is defined; otherwise env = gate ? 15 : 0.
module multi_voice_synth #(
  parameter int NUM_VOICES = 3,
  parameter int PERIOD_W   = 12,
  parameter int PWM_W      = 8,
  parameter int ENV_DIV    = 256,
  parameter int MIX_SHIFT  = 2,
  localparam int ADDR_W    = $clog2(4*NUM_VOICES+4)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_strobe,
  input  logic [ADDR_W-1:0]     address,
  input  logic [7:0]            data,
  output logic                  signal_out,
  output logic [PWM_W-1:0]      mix_level,
  output logic [NUM_VOICES-1:0] voice_wave
);
  localparam int SUM_W = (PWM_W > 11) ? PWM_W + 1 : 12;
  localparam logic [ADDR_W-1:0] GLOBAL_BASE = ADDR_W'(4*NUM_VOICES);

  logic [PERIOD_W-1:0]   periodShadow [NUM_VOICES];
  logic [PERIOD_W-1:0]   periodActive [NUM_VOICES];
  logic [PERIOD_W-1:0]   toneCnt      [NUM_VOICES];
  logic [3:0]            vol          [NUM_VOICES];
  logic [3:0]            env          [NUM_VOICES];
  logic [NUM_VOICES-1:0] enable, gate, wave;
  logic [3:0]            noiseVol;
  logic                  noiseEn;
  logic [2:0]            noiseDiv;
`ifdef SYNTH_ENV_EN
  logic [3:0]            atkRate      [NUM_VOICES];
  logic [3:0]            decRate      [NUM_VOICES];
  logic [3:0]            sustain;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        periodShadow[v] <= '0;
        vol[v]          <= '0;
`ifdef SYNTH_ENV_EN
        atkRate[v]      <= '0;
        decRate[v]      <= '0;
`endif
      end
      enable   <= '0;
      gate     <= '0;
      noiseVol <= '0;
      noiseEn  <= 1'b0;
      noiseDiv <= '0;
`ifdef SYNTH_ENV_EN
      sustain  <= '0;
`endif
    end else if (write_strobe) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (address == ADDR_W'(4*v))   periodShadow[v][7:0] <= data;
        if (address == ADDR_W'(4*v+1)) periodShadow[v][PERIOD_W-1:8] <= data[PERIOD_W-9:0];
        if (address == ADDR_W'(4*v+2)) begin
          vol[v]    <= data[3:0];
          enable[v] <= data[4];
          gate[v]   <= data[5];
        end
`ifdef SYNTH_ENV_EN
        if (address == ADDR_W'(4*v+3)) begin
          atkRate[v] <= data[3:0];
          decRate[v] <= data[7:4];
        end
`endif
      end
      if (address == GLOBAL_BASE) begin
        noiseVol <= data[3:0];
        noiseEn  <= data[4];
        noiseDiv <= data[7:5];
      end
`ifdef SYNTH_ENV_EN
      if (address == GLOBAL_BASE + ADDR_W'(1)) sustain <= data[3:0];
`endif
    end
  end

  // period_active reloads only at a toggle (or while idle), so a new period never cuts a half-cycle short
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!rst) begin
        wave[v]         <= 1'b0;
        toneCnt[v]      <= '0;
        periodActive[v] <= '0;
      end else if (!enable[v] || periodActive[v] == '0) begin
        wave[v]         <= 1'b0;
        toneCnt[v]      <= '0;
        periodActive[v] <= periodShadow[v];
      end else if (toneCnt[v] == periodActive[v] - PERIOD_W'(1)) begin
        wave[v]         <= ~wave[v];
        toneCnt[v]      <= '0;
        periodActive[v] <= periodShadow[v];
      end else begin
        toneCnt[v]      <= toneCnt[v] + PERIOD_W'(1);
      end
    end
  end

`ifdef SYNTH_ENV_EN
  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} envState_t;
  localparam int ENV_DIV_W = $clog2(ENV_DIV);

  envState_t             envState     [NUM_VOICES];
  envState_t             envStateNext [NUM_VOICES];
  logic [3:0]            envLevel     [NUM_VOICES];
  logic [3:0]            envLevelNext [NUM_VOICES];
  logic [3:0]            stepCnt      [NUM_VOICES];
  logic [3:0]            stepCntNext  [NUM_VOICES];
  logic [NUM_VOICES-1:0] gatePrev, envStep;
  logic [ENV_DIV_W-1:0]  envDivCnt;
  logic                  envTick;

  assign envTick = (envDivCnt == ENV_DIV_W'(ENV_DIV-1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      envDivCnt <= '0;
      gatePrev  <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        envState[v] <= IDLE;
        envLevel[v] <= '0;
        stepCnt[v]  <= '0;
      end
    end else begin
      envDivCnt <= envTick ? '0 : envDivCnt + ENV_DIV_W'(1);
      gatePrev  <= gate;
      for (int v = 0; v < NUM_VOICES; v++) begin
        envState[v] <= envStateNext[v];
        envLevel[v] <= envLevelNext[v];
        stepCnt[v]  <= stepCntNext[v];
      end
    end
  end

  // stepCnt counts envelope ticks; a rate step fires when it has seen rate+1 ticks
  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++)
      envStep[v] = envTick && (stepCnt[v] == ((envState[v] == ATTACK) ? atkRate[v] : decRate[v]));
  end

  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      envStateNext[v] = envState[v];
      envLevelNext[v] = envLevel[v];
      stepCntNext[v]  = envTick ? (envStep[v] ? 4'd0 : stepCnt[v] + 4'd1) : stepCnt[v];
      env[v]          = envLevel[v];
      if (gate[v] && !gatePrev[v]) begin
        envStateNext[v] = ATTACK;
        stepCntNext[v]  = '0;
      end else if (!gate[v] && gatePrev[v]) begin
        envStateNext[v] = RELEASE;
        stepCntNext[v]  = '0;
      end else begin
        case (envState[v])
          ATTACK: begin
            if (envLevel[v] == 4'd15) envStateNext[v] = DECAY;
            else if (envStep[v]) begin
              envLevelNext[v] = envLevel[v] + 4'd1;
              if (envLevel[v] == 4'd14) envStateNext[v] = DECAY;
            end
          end
          DECAY: begin
            if (envLevel[v] <= sustain) envStateNext[v] = SUSTAIN;
            else if (envStep[v]) begin
              envLevelNext[v] = envLevel[v] - 4'd1;
              if (envLevel[v] - 4'd1 <= sustain) envStateNext[v] = SUSTAIN;
            end
          end
          RELEASE: begin
            if (envLevel[v] == 4'd0) envStateNext[v] = IDLE;
            else if (envStep[v]) begin
              envLevelNext[v] = envLevel[v] - 4'd1;
              if (envLevel[v] == 4'd1) envStateNext[v] = IDLE;
            end
          end
          SUSTAIN: stepCntNext[v] = '0;
          default: stepCntNext[v] = '0;
        endcase
      end
    end
  end
`else
  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++)
      env[v] = gate[v] ? 4'hF : 4'h0;
  end
`endif

  logic [15:0] lfsr;
  logic [6:0]  noiseCnt, noiseMask;
  logic        noiseStep, noiseBit;

  assign noiseMask = 7'((8'd1 << noiseDiv) - 8'd1);
  assign noiseStep = noiseEn && ((noiseCnt & noiseMask) == noiseMask);
  assign noiseBit  = lfsr[0] & noiseEn;

  // right-shifting Fibonacci form of taps 16,14,13,11
  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr     <= 16'hACE1;
      noiseCnt <= '0;
    end else if (!noiseEn) begin
      noiseCnt <= '0;
    end else begin
      noiseCnt <= noiseCnt + 7'd1;
      if (noiseStep) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
  end

  logic [SUM_W-1:0] mixSum, mixShifted;
  logic [PWM_W-1:0] mixSat;

  always_comb begin
    mixSum = noiseBit ? SUM_W'({noiseVol, 4'b0000}) : '0;
    for (int v = 0; v < NUM_VOICES; v++)
      if (wave[v]) mixSum = mixSum + SUM_W'({4'b0000, vol[v]} * {4'b0000, env[v]});
    mixShifted = mixSum >> MIX_SHIFT;
    mixSat     = (mixShifted > SUM_W'((1 << PWM_W) - 1)) ? '1 : mixShifted[PWM_W-1:0];
  end

  logic [PWM_W-1:0] pwmCnt, duty;

  // full-scale duty holds the pin high so a saturated mix gives a flat top
  always_ff @(posedge clk) begin
    if (!rst) begin
      mix_level  <= '0;
      pwmCnt     <= '0;
      duty       <= '0;
      signal_out <= 1'b0;
    end else begin
      mix_level  <= mixSat;
      pwmCnt     <= pwmCnt + PWM_W'(1);
      if (&pwmCnt) duty <= mix_level;
      signal_out <= (pwmCnt < duty) || (&duty);
    end
  end

  assign voice_wave = wave;
endmodule
